// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-sequencer state encoding and the address-width derivation.
package regfile_pkg;

   typedef enum logic [1:0] {
      CLR_IDLE  = 2'd0,
      CLR_CLEAR = 2'd1,
      CLR_DONE  = 2'd2
   } clr_state_e;

   function automatic int calc_aw(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks the array one register per cycle,
// then pulses clr_done for a single cycle before returning to idle.
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   parameter int AW       = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);
   localparam logic [AW-1:0] PTR_FIRST = (ZERO_REG != 0) ? AW'(1) : '0;

   clr_state_e    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLR_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      clr_we   = 1'b0;
      clr_done = 1'b0;
      unique case (state_q)
         CLR_IDLE: begin
            if (clr_req) begin
               state_d = CLR_CLEAR;
               ptr_d   = PTR_FIRST;
            end
         end
         CLR_CLEAR: begin
            clr_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) state_d = CLR_DONE;
         end
         CLR_DONE: begin
            clr_done = 1'b1;
            state_d  = CLR_IDLE;
         end
         default: state_d = CLR_IDLE;
      endcase
   end

   assign clr_busy = (state_q != CLR_IDLE);
   assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional x0 hardwiring,
// write-to-read bypass and a sequenced bulk-clear engine.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NRD*calc_aw(NREGS)-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]              rd_data,
   input  logic [NWR-1:0]                   wr_en,
   input  logic [NWR*calc_aw(NREGS)-1:0]    wr_addr,
   input  logic [NWR*XLEN-1:0]              wr_data,
   output logic                             wr_stall,
   input  logic                             clr_req,
   output logic                             clr_busy,
   output logic                             clr_done
);

   localparam int AW = calc_aw(NREGS);

   logic [XLEN-1:0] mem_q [NREGS];
   logic [NREGS-1:0] mem_we;
   logic [XLEN-1:0] mem_wd [NREGS];

   logic [AW-1:0]   waddr [NWR];
   logic [XLEN-1:0] wdata [NWR];
   logic [NWR-1:0]  wacc;

   logic [AW-1:0]   raddr [NRD];
   logic [XLEN-1:0] rval  [NRD];

   logic          clr_we;
   logic [AW-1:0] clr_addr;

   regfile_clr_seq #(
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign wr_stall = clr_busy;

   // A write is accepted only when not stalled and not aimed at a hardwired x0.
   always_comb begin
      for (int j = 0; j < NWR; j++) begin
         waddr[j] = wr_addr[j*AW +: AW];
         wdata[j] = wr_data[j*XLEN +: XLEN];
         wacc[j]  = wr_en[j] & ~wr_stall &
                    ~((ZERO_REG != 0) && (waddr[j] == '0));
      end
   end

   // Later ports overwrite earlier ones, so the highest index wins.
   always_comb begin
      mem_we = '0;
      for (int r = 0; r < NREGS; r++) mem_wd[r] = '0;
      for (int j = 0; j < NWR; j++) begin
         if (wacc[j]) begin
            mem_we[waddr[j]] = 1'b1;
            mem_wd[waddr[j]] = wdata[j];
         end
      end
      if (clr_we) begin
         mem_we[clr_addr] = 1'b1;
         mem_wd[clr_addr] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (mem_we[r]) mem_q[r] <= mem_wd[r];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         raddr[i] = rd_addr[i*AW +: AW];
         if ((ZERO_REG != 0) && (raddr[i] == '0)) rval[i] = '0;
         else rval[i] = mem_q[raddr[i]];
         if (BYPASS != 0) begin
            for (int j = 0; j < NWR; j++) begin
               if (wacc[j] && (waddr[j] == raddr[i])) rval[i] = wdata[j];
            end
         end
         rd_data[i*XLEN +: XLEN] = rval[i];
      end
   end

endmodule
